// File: rtl/score_digit_encoder.sv
// Binary-to-ASCII score digit encoder using sequential double dabble.
// Produces four ASCII digits plus font ROM row-0 addresses, saturating at 9999.
module score_digit_encoder (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [7:0]  digit3,
    output logic [7:0]  digit2,
    output logic [7:0]  digit1,
    output logic [7:0]  digit0,
    output logic [10:0] digit_addr3,
    output logic [10:0] digit_addr2,
    output logic [10:0] digit_addr1,
    output logic [10:0] digit_addr0
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  digit_q [4];
    logic [7:0]  digit_d [4];
    logic [10:0] addr_q  [4];
    logic [10:0] addr_d  [4];

    logic [19:0] bcd_adj;
    logic [35:0] sh;
    logic        ovf_now;
    logic [3:0]  nib [4];

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == 5'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy        = (state_q != IDLE);
        done        = done_q;
        overflow    = ovf_q;
        digit3      = digit_q[3];
        digit2      = digit_q[2];
        digit1      = digit_q[1];
        digit0      = digit_q[0];
        digit_addr3 = addr_q[3];
        digit_addr2 = addr_q[2];
        digit_addr1 = addr_q[1];
        digit_addr0 = addr_q[0];
    end

    // Add-3 correction on every BCD nibble, then one combined left shift
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 5; i++) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4]
                + ((bcd_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
        end
        sh = {bcd_adj, bin_q} << 1;
    end

    // Final digit selection, saturating to 9999 above four digits
    always_comb begin
        ovf_now = (bcd_q[19:16] != 4'd0);
        for (int i = 0; i < 4; i++) begin
            nib[i] = ovf_now ? 4'd9 : bcd_q[4*i +: 4];
        end
    end

    // Datapath next-state
    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        ovf_d  = ovf_q;
        for (int i = 0; i < 4; i++) begin
            digit_d[i] = digit_q[i];
            addr_d[i]  = addr_q[i];
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d = value;
                    bcd_d = '0;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                bcd_d = sh[35:16];
                bin_d = sh[15:0];
                cnt_d = cnt_q + 5'd1;
            end
            DONE: begin
                done_d = 1'b1;
                ovf_d  = ovf_now;
                for (int i = 0; i < 4; i++) begin
                    digit_d[i] = 8'h30 + {4'h0, nib[i]};
                    addr_d[i]  = {3'b011, nib[i], 4'b0000};
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= 8'h30;
                addr_q[i]  <= 11'h300;
            end
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= digit_d[i];
                addr_q[i]  <= addr_d[i];
            end
        end
    end

endmodule
